// File: rtl/s2p_pkg.sv
`default_nettype none
// ============================================================================
// Module   : s2p_pkg
// Purpose  : Shared types and constants for the serial-to-parallel front end.
// Revision : 1.0 - initial release
// ============================================================================
package s2p_pkg;

  localparam int WORD_W = 32;
  localparam int SEL_W  = 5;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/s2p_bit_collector.sv
`default_nettype none
// ============================================================================
// Module   : s2p_bit_collector
// Purpose  : Counts serial bits, drives the bit index to an external 5-to-32
//            one-hot decoder, uses the returned one-hot as a per-bit write
//            enable to assemble a word, and offers it on a valid/ready port.
// Revision : 1.0 - initial release
// ============================================================================
module s2p_bit_collector
  import s2p_pkg::*;
#(
  parameter int FRAME_BITS = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_sdi,
  input  logic              i_sdi_valid,
  output logic [SEL_W-1:0]  o_sel,
  input  logic [WORD_W-1:0] i_onehot,
  output logic [WORD_W-1:0] o_pdata,
  output logic              o_pvalid,
  input  logic              i_pready,
  output logic              o_busy,
  output logic              o_overrun,
  output logic              o_dec_err,
  output logic              o_frame_err,
  input  logic              i_clr_err
);

  // Index of the last bit of a frame, and the mask forcing unused word bits to 0.
  localparam logic [SEL_W-1:0]  c_last_sel   = SEL_W'(FRAME_BITS - 1);
  localparam logic [WORD_W-1:0] c_frame_mask = WORD_W'((64'd1 << FRAME_BITS) - 64'd1);

  state_t              r_state;
  logic [SEL_W-1:0]    r_sel;
  logic [WORD_W-1:0]   r_shadow;
  logic [WORD_W-1:0]   r_pdata;
  logic                r_pvalid;
  logic                r_overrun;
  logic                r_dec_err;
  logic                r_frame_err;

  logic                w_in_shift;
  logic                w_capture;
  logic [SEL_W-1:0]    w_idx;
  logic                w_last;
  logic [WORD_W-1:0]   w_merged;
  logic [WORD_W-1:0]   w_word;
  logic                w_done;
  logic                w_load;
  logic                w_dec_bad;
  logic                w_restart;

  assign w_in_shift = (r_state == ST_SHIFT);
  // A bit is taken in SHIFT, or in any cycle carrying START (frame begins there).
  assign w_capture  = i_sdi_valid && (w_in_shift || i_start);
  // START always rewinds the frame, so the bit written in that cycle is bit 0.
  assign w_idx      = i_start ? '0 : r_sel;
  assign w_last     = (w_idx == c_last_sel);
  // In a START cycle the shadow is being cleared and SEL may still point at an
  // abandoned mid-frame position, so bit 0 is written directly instead of via
  // the decoder return path; otherwise the one-hot is the write enable.
  assign w_merged   = i_start ? {{(WORD_W-1){1'b0}}, i_sdi}
                              : ((r_shadow & ~i_onehot) | (i_sdi ? i_onehot : '0));
  assign w_word     = w_merged & c_frame_mask;
  assign w_done     = w_capture && w_last;
  assign w_load     = w_done && (!r_pvalid || i_pready);
  assign w_dec_bad  = w_capture && (i_onehot != (WORD_W'(1) << r_sel));
  assign w_restart  = i_start && w_in_shift;

  // Frame state machine: bit counter, shadow word assembly and IDLE/SHIFT control.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_sel    <= '0;
      r_shadow <= '0;
    end else if (w_capture) begin
      if (w_last) begin
        r_state  <= ST_IDLE;
        r_sel    <= '0;
        r_shadow <= '0;
      end else begin
        r_state  <= ST_SHIFT;
        r_sel    <= w_idx + 1'b1;
        r_shadow <= w_word;
      end
    end else if (i_start) begin
      r_state  <= ST_SHIFT;
      r_sel    <= '0;
      r_shadow <= '0;
    end
  end

  // Output register: load a completed word when the slot is free or draining.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pdata  <= '0;
      r_pvalid <= 1'b0;
    end else if (w_load) begin
      r_pdata  <= w_word;
      r_pvalid <= 1'b1;
    end else if (r_pvalid && i_pready) begin
      r_pvalid <= 1'b0;
    end
  end

  // Sticky error flags; a set event in the same cycle overrides the clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_overrun   <= 1'b0;
      r_dec_err   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_done && !w_load) r_overrun   <= 1'b1;
      else if (i_clr_err)    r_overrun   <= 1'b0;
      if (w_dec_bad)         r_dec_err   <= 1'b1;
      else if (i_clr_err)    r_dec_err   <= 1'b0;
      if (w_restart)         r_frame_err <= 1'b1;
      else if (i_clr_err)    r_frame_err <= 1'b0;
    end
  end

  assign o_sel       = r_sel;
  assign o_pdata     = r_pdata;
  assign o_pvalid    = r_pvalid;
  assign o_busy      = w_in_shift;
  assign o_overrun   = r_overrun;
  assign o_dec_err   = r_dec_err;
  assign o_frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: doc/s2p_bit_collector.md
# s2p_bit_collector

Serial-capture front end of the serial-to-parallel interface. It counts incoming serial bits and drives the 5-bit bit index into the existing 5-to-32 one-hot decoder. It uses the decoder's one-hot output as a per-bit write enable to assemble a word, then presents the completed word on a valid/ready parallel port. It sits directly upstream of the decoder, which produces its select, and also directly downstream of it, because it consumes the decoder's one-hot output.

## Interface
- FRAME_BITS, 32: bits per frame, legal range 1..32; word bits [31:FRAME_BITS] always 0.
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- START  in  1  frame-start pulse.
- SDI  in  1  serial data bit.
- SDI_VALID  in  1  SDI qualifier; one bit per cycle when high.
- SEL  out  5  bit index to decoder (registered).
- ONEHOT  in  32  decoder output for the current SEL (combinational return path).
- PDATA  out  32  assembled word.
- PVALID  out  1  PDATA valid.
- PREADY  in  1  consumer accepts PDATA.
- BUSY  out  1  frame in progress.
- OVERRUN  out  1  sticky: a completed frame was dropped.
- DEC_ERR  out  1  sticky: ONEHOT inconsistent with SEL.
- FRAME_ERR  out  1  sticky: START arrived mid-frame.
- CLR_ERR  in  1  synchronous clear of all sticky flags.

## Operation
- Reset values: SEL=0, PDATA=0, PVALID=0, BUSY=0, OVERRUN=0, DEC_ERR=0, FRAME_ERR=0, shadow word=0, state IDLE.
- States: IDLE and SHIFT.
- IDLE:
  - SDI_VALID is ignored.
  - START moves to SHIFT, with SEL=0 and shadow cleared.
  - If SDI_VALID is also high in the START cycle, bit 0 is captured in that cycle.
- SHIFT:
  - Each SDI_VALID writes shadow = (shadow & ~ONEHOT) | (SDI ? ONEHOT : 0), then SEL increments.
  - Bit i of the serial stream lands in word bit i (LSB first).
- Completion: SDI_VALID while SEL == FRAME_BITS-1.
  - The word (shadow with the final bit merged) is offered to the output register.
  - State returns to IDLE and SEL returns to 0.
- Output register loads the completed word when PVALID=0, or when PVALID=1 and PREADY=1 in the same cycle; PVALID=1 after the load.
- Otherwise the new word is dropped, the old PDATA is kept, and OVERRUN is set.
- Handshake: PVALID && PREADY with no load in that cycle clears PVALID. PDATA holds its value until replaced.
- START in SHIFT:
  - Sets FRAME_ERR and restarts the frame (SEL=0, shadow cleared).
  - Bit 0 is captured if SDI_VALID is also high in that cycle.
- Decoder check: on every SDI_VALID in SHIFT (or in the START cycle), DEC_ERR is set unless ONEHOT == (1 << SEL). The capture still proceeds.
- CLR_ERR clears sticky flags. A set event in the same cycle wins.
- BUSY = (state == SHIFT).

## Timing
- SEL is a register, so ONEHOT is settled within the same cycle. The capture uses ONEHOT sampled at the edge where SDI_VALID is high.
- Latency: PVALID rises on the edge that samples the last bit, i.e. visible the cycle after the final SDI_VALID.
- Throughput: one bit per cycle. Back-to-back frames need one START per frame; START may coincide with the first bit.
- Asynchronous reset mid-frame discards the partial word and PDATA immediately.
- FRAME_BITS=1: START with SDI_VALID completes the frame in a single cycle.

## Structure
- Shared package `s2p_pkg`: state enum (IDLE, SHIFT), WORD_W=32, SEL_W=5 constants.
- No sub-modules inside. The decoder stays a separate instance wired SEL→SEL, OUT→ONEHOT at the parent level; the bench instantiates it alongside this block.

## Test plan
- Reset, START, then 32 consecutive SDI_VALID with bits of 0xA5C3_0F96 LSB first, PREADY=1 → PVALID one cycle after the last bit, PDATA=0xA5C30F96, then PVALID=0.
- FRAME_BITS=8, bits 0x3C, PREADY=0 → PDATA=0x0000003C held. Second frame 0xFF completes before PREADY → OVERRUN=1, PDATA stays 0x3C.
- Completion in the same cycle as PREADY=1 with PVALID=1 → new word loads, PVALID stays 1, OVERRUN=0.
- START after 10 bits, then a full frame of 0x12345678 → FRAME_ERR=1, PDATA=0x12345678. CLR_ERR → FRAME_ERR=0.
- Force ONEHOT to 0x4 while SEL=1 → DEC_ERR=1.
- RST_N low mid-frame (bit 17) → all outputs at reset values immediately. A fresh frame of 0xDEADBEEF is then captured correctly.
